// File: rtl/execute_stage.sv
//------------------------------------------------------------------------------
// Module      : execute_stage
// Description : Single-cycle integer execute stage (RV32I ALU, branches, jumps,
//               address generation) with registered results and a one-cycle
//               branch redirect pulse. Define EXECUTE_STAGE_MUL_EN to add an
//               iterative 32-cycle shift-add RV32M MUL unit that stalls
//               upstream while it runs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic [31:0] pc,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] imm,
  output logic [31:0] alu_out,
  output logic        alu_reg_w_en,
  output logic [4:0]  alu_rd,
  output logic        br_ctrl,
  output logic [31:0] br_target,
  output logic        stall
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_F7_M      = 7'b0000001;

  logic [31:0] r_alu_out;
  logic        r_we;
  logic [4:0]  r_rd;
  logic        r_br;
  logic [31:0] r_tgt;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic        w_squash;
  logic        w_is_m;
  logic [31:0] w_alu_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic        w_wen;
  logic        w_take;
  logic [31:0] w_tgt;
  logic        w_mul_done;
  logic [31:0] w_mul_sum;
  logic        w_unused;

  assign w_opcode = ins[6:0];
  assign w_f3     = ins[14:12];
  assign w_f7     = ins[31:25];
  assign w_rd     = ins[11:7];
  // The instruction behind a redirect is on the wrong path.
  assign w_squash = r_br;
  assign w_is_m   = (w_opcode == c_OP_R) && (w_f7 == c_F7_M);
  assign w_alu_b  = (w_opcode == c_OP_R) ? op_b : imm;
  assign w_shamt  = w_alu_b[4:0];
  // Register source indices are resolved upstream.
  assign w_unused = ^ins[24:15];

  // Integer ALU shared by R-type and I-type
  always_comb begin
    w_alu = 32'd0;
    case (w_f3)
      3'b000:  w_alu = ((w_opcode == c_OP_R) && ins[30]) ? (op_a - w_alu_b) : (op_a + w_alu_b);
      3'b001:  w_alu = op_a << w_shamt;
      3'b010:  w_alu = {31'd0, $signed(op_a) < $signed(w_alu_b)};
      3'b011:  w_alu = {31'd0, op_a < w_alu_b};
      3'b100:  w_alu = op_a ^ w_alu_b;
      3'b101:  w_alu = ins[30] ? 32'($signed(op_a) >>> w_shamt) : (op_a >> w_shamt);
      3'b110:  w_alu = op_a | w_alu_b;
      default: w_alu = op_a & w_alu_b;
    endcase
  end

  // Opcode decode: result, writeback enable and redirect decision
  always_comb begin
    w_result = 32'd0;
    w_wen    = 1'b0;
    w_take   = 1'b0;
    w_tgt    = pc + imm;
    case (w_opcode)
      c_OP_R: begin
        if (!w_is_m) begin
          w_result = w_alu;
          w_wen    = 1'b1;
        end
      end
      c_OP_I: begin
        w_result = w_alu;
        w_wen    = 1'b1;
      end
      c_OP_LUI: begin
        w_result = imm;
        w_wen    = 1'b1;
      end
      c_OP_AUIPC: begin
        w_result = pc + imm;
        w_wen    = 1'b1;
      end
      c_OP_JAL: begin
        w_result = pc + 32'd4;
        w_wen    = 1'b1;
        w_take   = 1'b1;
      end
      c_OP_JALR: begin
        w_result = pc + 32'd4;
        w_wen    = 1'b1;
        w_take   = 1'b1;
        w_tgt    = (op_a + imm) & ~32'd1;
      end
      c_OP_LOAD, c_OP_STORE: begin
        w_result = op_a + imm;
      end
      c_OP_BRANCH: begin
        case (w_f3)
          3'b000:  w_take = (op_a == op_b);
          3'b001:  w_take = (op_a != op_b);
          3'b100:  w_take = ($signed(op_a) <  $signed(op_b));
          3'b101:  w_take = ($signed(op_a) >= $signed(op_b));
          3'b110:  w_take = (op_a <  op_b);
          3'b111:  w_take = (op_a >= op_b);
          default: w_take = 1'b0;
        endcase
      end
      default: begin
        w_result = 32'd0;
      end
    endcase
    w_wen = w_wen && (w_rd != 5'd0);
    if (w_squash) begin
      w_result = 32'd0;
      w_wen    = 1'b0;
      w_take   = 1'b0;
    end
  end

`ifdef EXECUTE_STAGE_MUL_EN
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mul_state_t;

  mul_state_t  r_state;
  mul_state_t  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic        w_mul_go;

  // A squashed MUL never starts, so it must not hold the pipe either.
  assign w_mul_go   = w_is_m && (w_f3 == 3'b000) && !w_squash;
  assign w_mul_done = (r_state == S_BUSY) && (r_cnt == 5'd31);
  // Final partial product folds in on the completing edge.
  assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : 32'd0);

  // MUL state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // MUL next state and pipeline stall
  always_comb begin
    w_state_nxt = r_state;
    stall       = w_mul_go && !w_mul_done;
    case (r_state)
      S_IDLE:  if (w_mul_go) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 5'd31) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-add datapath: latch on start, one multiplier bit per busy edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
    end else if ((r_state == S_IDLE) && w_mul_go) begin
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_mcand  <= op_a;
      r_mplier <= op_b;
    end else if (r_state == S_BUSY) begin
      r_cnt    <= r_cnt + 5'd1;
      r_acc    <= w_mul_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign stall      = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_sum  = 32'd0;
`endif

  // Output registers: hold quiet while stalled, commit MUL or ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out <= 32'd0;
      r_we      <= 1'b0;
      r_rd      <= 5'd0;
      r_br      <= 1'b0;
      r_tgt     <= 32'd0;
    end else if (stall) begin
      r_we      <= 1'b0;
      r_br      <= 1'b0;
    end else if (w_mul_done) begin
      r_alu_out <= w_mul_sum;
      r_we      <= (w_rd != 5'd0);
      r_rd      <= w_rd;
      r_br      <= 1'b0;
    end else begin
      r_alu_out <= w_result;
      r_we      <= w_wen;
      r_rd      <= w_rd;
      r_br      <= w_take;
      r_tgt     <= w_tgt;
    end
  end

  assign alu_out      = r_alu_out;
  assign alu_reg_w_en = r_we;
  assign alu_rd       = r_rd;
  assign br_ctrl      = r_br;
  assign br_target    = r_tgt;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_execute_stage
// Description : Randomised scoreboard bench for execute_stage with directed
//               corner vectors and a reset-during-MUL scenario.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = 32'h00000033;
  logic [31:0] pc = 32'd0, op_a = 32'd0, op_b = 32'd0, imm = 32'd0;
  logic [31:0] alu_out, br_target;
  logic        alu_reg_w_en, br_ctrl, stall;
  logic [4:0]  alu_rd;

  execute_stage dut (
    .clk(clk), .rst(rst), .ins(ins), .pc(pc), .op_a(op_a), .op_b(op_b), .imm(imm),
    .alu_out(alu_out), .alu_reg_w_en(alu_reg_w_en), .alu_rd(alu_rd),
    .br_ctrl(br_ctrl), .br_target(br_target), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] out;
    logic        chk_out;
    logic        br;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  logic prev_taken = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural meaning of one instruction.
  function automatic exp_t model(input logic [31:0] i, p, a, b, im, input logic sq);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [31:0] y;
    int unsigned sh;
    logic signed [31:0] sa, sy, sb;
    logic [63:0] wide;
    logic wr;
    opc = i[6:0]; f3 = i[14:12];
    y  = (opc == 7'b0110011) ? b : im;
    sh = y % 32;
    sa = a; sy = y; sb = b;
    e = '0; e.rd = i[11:7]; e.chk_out = 1'b1; e.tgt = p + im; wr = 1'b0;
    case (opc)
      7'b0110011, 7'b0010011: begin
        if (opc == 7'b0110011 && i[31:25] == 7'b0000001) begin
`ifdef EXECUTE_STAGE_MUL_EN
          if (f3 == 3'b000) begin
            wide = 64'(a) * 64'(b);
            e.out = wide[31:0]; wr = 1'b1;
          end else e.chk_out = 1'b0;
`else
          e.chk_out = 1'b0;
`endif
        end else begin
          wr = 1'b1;
          case (f3)
            3'd0: e.out = (opc == 7'b0110011 && i[30]) ? a - y : a + y;
            3'd1: e.out = 32'(64'(a) * (64'd1 << sh));
            3'd2: e.out = (sa < sy) ? 32'd1 : 32'd0;
            3'd3: e.out = (a < y) ? 32'd1 : 32'd0;
            3'd4: e.out = a ^ y;
            3'd5: begin
              wide = i[30] ? {{32{a[31]}}, a} : {32'd0, a};
              e.out = 32'(wide >> sh);
            end
            3'd6: e.out = a | y;
            default: e.out = a & y;
          endcase
        end
      end
      7'b0110111: begin e.out = im; wr = 1'b1; end
      7'b0010111: begin e.out = p + im; wr = 1'b1; end
      7'b1101111: begin e.out = p + 4; wr = 1'b1; e.br = 1'b1; end
      7'b1100111: begin e.out = p + 4; wr = 1'b1; e.br = 1'b1; e.tgt = (a + im) & 32'hFFFF_FFFE; end
      7'b0000011, 7'b0100011: e.out = a + im;
      7'b1100011: begin
        e.chk_out = 1'b0;
        case (f3)
          3'd0: e.br = (a == b);
          3'd1: e.br = (a != b);
          3'd4: e.br = (sa < sb);
          3'd5: e.br = (sa >= sb);
          3'd6: e.br = (a < b);
          3'd7: e.br = (a >= b);
          default: e.br = 1'b0;
        endcase
      end
      default: e.out = 32'd0;
    endcase
    e.we = wr && (i[11:7] != 0);
    if (sq) begin e.we = 1'b0; e.br = 1'b0; e.chk_out = 1'b0; end
    return e;
  endfunction

  function automatic int mul_cycles(input logic [31:0] i, input logic sq);
`ifdef EXECUTE_STAGE_MUL_EN
    return (i[6:0] == 7'b0110011 && i[31:25] == 7'b0000001 && i[14:12] == 3'b000 && !sq) ? 32 : 0;
`else
    return 0;
`endif
  endfunction

  // Present one instruction (called at posedge+1), queue one expectation per output cycle.
  task automatic issue(input logic [31:0] i, p, a, b, im);
    exp_t e, quiet;
    int ns;
    ins = i; pc = p; op_a = a; op_b = b; imm = im;
    e  = model(i, p, a, b, im, prev_taken);
    ns = mul_cycles(i, prev_taken);
    quiet = '0;
    for (int k = 0; k < ns; k++) begin
      @(negedge clk); chk("stall_busy", {31'd0, stall}, 32'd1);
      @(posedge clk); #1; q.push_back(quiet);
    end
    @(negedge clk); chk("stall_free", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; q.push_back(e);
    prev_taken = e.br;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] edges [5];
    edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Monitor: compare every output cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("alu_reg_w_en", {31'd0, alu_reg_w_en}, {31'd0, e.we});
      if (e.we) chk("alu_rd", {27'd0, alu_rd}, {27'd0, e.rd});
      if (e.chk_out) chk("alu_out", alu_out, e.out);
      chk("br_ctrl", {31'd0, br_ctrl}, {31'd0, e.br});
      if (e.br) chk("br_target", br_target, e.tgt);
    end
  end

  initial begin
    logic [6:0] opcs [11];
    logic [6:0] f7s [3];
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
             7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111, 7'b0001011};
    f7s  = '{7'b0000000, 7'b0100000, 7'b0000001};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_w_en", {31'd0, alu_reg_w_en}, 32'd0);
    chk("rst_rd", {27'd0, alu_rd}, 32'd0);
    chk("rst_br_ctrl", {31'd0, br_ctrl}, 32'd0);
    chk("rst_br_target", br_target, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // Directed corners
    issue(32'h0020_81B3, 32'h0, 32'h7FFF_FFFF, 32'd1, 32'd0);           // ADD x3
    issue(32'h4020_D233, 32'h4, 32'hF000_0000, 32'd36, 32'd0);          // SRA x4
    issue(32'h0020_A2B3, 32'h8, 32'hFFFF_FFFF, 32'd0, 32'd0);           // SLT x5
    issue(32'h0020_B2B3, 32'hC, 32'hFFFF_FFFF, 32'd0, 32'd0);           // SLTU x5
    issue(32'h4020_8333, 32'h10, 32'd0, 32'd1, 32'd0);                  // SUB x6
    issue(32'h0020_C063, 32'h100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8); // BLT taken
    issue(32'h0020_82B3, 32'h104, 32'd1, 32'd2, 32'd0);                 // ADD x5 (wrong path)
    issue(32'h0000_80E7, 32'h40, 32'h203, 32'd0, 32'd0);                // JALR x1
    issue(32'h0000_0033, 32'h44, 32'd5, 32'd6, 32'd0);                  // NOP (wrong path)
    issue(32'h0230_83B3, 32'h48, 32'hFFFF_FFFF, 32'd3, 32'd0);          // MUL x7
    issue(32'h0000_0013, 32'h4C, 32'd0, 32'd0, 32'd0);                  // ADDI x0

    // Random stream
    for (int n = 0; n < 300; n++) begin
      logic [6:0] opc;
      logic [31:0] word;
      opc  = opcs[$urandom_range(0, 10)];
      word = $urandom;
      word[6:0] = opc;
      if (opc == 7'b0110011) word[31:25] = f7s[$urandom_range(0, 2)];
      issue(word, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rnd_val(), rnd_val(), rnd_val());
    end
    issue(32'h0000_0033, 32'h0, 32'd0, 32'd0, 32'd0);
    issue(32'h0000_0033, 32'h0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    // Reset ten edges into a MUL x7
    @(posedge clk); #1;
    ins = 32'h0230_83B3; op_a = 32'hFFFF_FFFF; op_b = 32'd3; imm = 32'd0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ins = 32'h0000_0033; op_a = 32'd0; op_b = 32'd0;
    @(negedge clk);
    chk("mrst_alu_out", alu_out, 32'd0);
    chk("mrst_w_en", {31'd0, alu_reg_w_en}, 32'd0);
    chk("mrst_rd", {27'd0, alu_rd}, 32'd0);
    chk("mrst_br_ctrl", {31'd0, br_ctrl}, 32'd0);
    chk("mrst_br_target", br_target, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("mrst_no_wb", {31'd0, alu_reg_w_en}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: none; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ins  in  32  decoded instruction from the read stage; a NOP is 32'h00000033.
REQ-005 pc  in  32  PC of ins.
REQ-006 op_a  in  32  rs1 value, already forwarded.
REQ-007 op_b  in  32  rs2 value, already forwarded.
REQ-008 imm  in  32  sign-extended immediate for ins.
REQ-009 alu_out  out  32  registered result; also the forwarding value for the read stage.
REQ-010 alu_reg_w_en  out  1  registered; alu_out targets alu_rd.
REQ-011 alu_rd  out  5  registered ins[11:7].
REQ-012 br_ctrl  out  1  registered one-cycle pulse: redirect fetch and squash younger instructions.
REQ-013 br_target  out  32  registered redirect address; valid only while br_ctrl=1.
REQ-014 stall  out  1  combinational; upstream SHALL hold ins/pc/op_a/op_b/imm stable while stall=1.

Function
REQ-015 An instruction SHALL be accepted on every edge where stall=0; non-MUL results SHALL appear one cycle after acceptance.
REQ-016 Opcode handling:
- 0110011 R-type, 0010011 I-type ALU: second operand is op_b (R) or imm (I).
- 0110111 LUI: result = imm.
- 0010111 AUIPC: result = pc+imm.
- 1101111 JAL, 1100111 JALR: result = pc+4.
- 0000011 load, 0100011 store: alu_out = op_a+imm, alu_reg_w_en=0.
REQ-017 ALU funct3 decode:
- 000 ADD; SUB when R-type and ins[30]=1.
- 001 SLL; 101 SRL, or SRA when ins[30]=1; shift amount is operand[4:0].
- 010 SLT signed; 011 SLTU unsigned; 100 XOR; 110 OR; 111 AND.
- All sums wrap modulo 2^32.
REQ-018 alu_reg_w_en SHALL be 1 only for R, I-ALU, LUI, AUIPC, JAL, JALR with rd!=0; it is 0 for all other cases.
REQ-019 Branch opcode 1100011 conditions by funct3:
- 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- Taken: br_ctrl=1, br_target=pc+imm. Not taken: br_ctrl=0.
- Other funct3 values: no effect.
REQ-020 JAL SHALL set br_ctrl=1, br_target=pc+imm; JALR SHALL set br_ctrl=1, br_target=(op_a+imm)&~1.
REQ-021 The instruction present in the cycle where br_ctrl=1 is wrong-path and SHALL be treated as a NOP: no writeback, no branch, no MUL start.
REQ-022 Unknown opcodes SHALL behave as NOP: alu_reg_w_en=0, br_ctrl=0, alu_out=0.

Reset
REQ-023 While rst=1 on an edge, every output register SHALL clear: alu_out=0, alu_reg_w_en=0, alu_rd=0, br_ctrl=0, br_target=0; the MUL FSM SHALL return to IDLE.
REQ-024 Reset during a MUL SHALL abort it with no writeback; stall SHALL be 0 in the cycle after reset.

Configuration
REQ-025 Macro EXECUTE_STAGE_MUL_EN SHALL gate the RV32M MUL instruction (opcode 0110011, funct7 0000001, funct3 000).
REQ-026 With EXECUTE_STAGE_MUL_EN, MUL SHALL use an iterative FSM IDLE->BUSY->IDLE:
- Accept edge: operands latch, counter=0, state=BUSY.
- Each BUSY edge: one shift-add step, counter+1.
- stall = (MUL present) && !(BUSY && counter==31).
- At the counter==31 edge: alu_out = low 32 bits of the product, write enable per REQ-018, state=IDLE.
- Result appears 32 edges after the accept edge.
- alu_reg_w_en=0 and br_ctrl=0 while BUSY.
REQ-027 Without EXECUTE_STAGE_MUL_EN, every funct7=0000001 instruction SHALL behave as a NOP, stall SHALL be tied to 0, and no FSM logic SHALL be synthesised. With the macro, the other funct7=0000001 funct3 values SHALL also behave as NOP.

Verification
REQ-028 ADD x3, op_a=32'h7FFFFFFF, op_b=1 -> next cycle alu_out=32'h80000000, alu_rd=3, alu_reg_w_en=1.
REQ-029 SRA with op_a=32'hF0000000, op_b=36 -> alu_out=32'hFF000000 (shift amount 4).
REQ-030 BLT with op_a=-1, op_b=0, pc=32'h100, imm=-8 -> br_ctrl=1 for exactly one cycle, br_target=32'hF8; the following ADD x5 produces no writeback.
REQ-031 JALR x1, pc=32'h40, op_a=32'h203, imm=0 -> alu_out=32'h44, br_target=32'h202.
REQ-032 With the macro, MUL x7, op_a=32'hFFFFFFFF, op_b=3, accepted at edge N -> stall high until the N+32 edge; alu_out=32'hFFFFFFFD and alu_reg_w_en=1 after edge N+32; without the macro -> alu_reg_w_en stays 0.
REQ-033 rst=1 at edge N+10 of the same MUL -> all outputs 0 after the edge, stall=0, no writeback to x7.
